// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives and observes it.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;

  logic        flush_i;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  flush_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output flush_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one transaction in flight.
// Define ARB_FAIRNESS_EN to let a starved fetch win after STARVE_LIMIT load/store grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitIf, StWaitLs} state_e;

  state_e state_q, state_d;
  logic   drop_q, drop_d;
  logic   sel_ls, sel_if;
  logic   if_rvalid;

`ifdef ARB_FAIRNESS_EN
  logic [2:0] starve_q, starve_d;
`endif

  always_comb begin
    state_d          = state_q;
    drop_d           = drop_q;
    if_rvalid        = 1'b0;
    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.ls_gnt_o     = 1'b0;
    bus.ls_rvalid_o  = 1'b0;
    bus.ls_rdata_o   = '0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.stall_o      = 1'b0;
    sel_ls           = bus.ls_req_i;
`ifdef ARB_FAIRNESS_EN
    starve_d = starve_q;
    if (bus.if_req_i && (32'(starve_q) >= STARVE_LIMIT)) begin
      sel_ls = 1'b0;
    end
`endif
    sel_if = bus.if_req_i & ~sel_ls;

    unique case (state_q)
      StIdle: begin
        bus.mem_req_o = bus.ls_req_i | bus.if_req_i;
        if (sel_ls) begin
          bus.mem_addr_o  = bus.ls_addr_i;
          bus.mem_we_o    = bus.ls_we_i;
          bus.mem_wdata_o = bus.ls_wdata_i;
          if (bus.mem_gnt_i) begin
            bus.ls_gnt_o = 1'b1;
            state_d      = StWaitLs;
`ifdef ARB_FAIRNESS_EN
            if (bus.if_req_i && (starve_q != 3'd7)) begin
              starve_d = starve_q + 3'd1;
            end
`endif
          end
        end else if (sel_if) begin
          bus.mem_addr_o = bus.if_addr_i;
          if (bus.mem_gnt_i) begin
            bus.if_gnt_o = 1'b1;
            state_d      = StWaitIf;
            drop_d       = bus.flush_i;
`ifdef ARB_FAIRNESS_EN
            starve_d = 3'd0;
`endif
          end
        end
      end
      StWaitLs: begin
        if (bus.mem_rvalid_i) begin
          bus.ls_rvalid_o = 1'b1;
          bus.ls_rdata_o  = bus.mem_rdata_i;
          state_d         = StIdle;
        end
      end
      StWaitIf: begin
        // A flush arriving together with the response still kills it.
        if (bus.mem_rvalid_i) begin
          if (!(drop_q || bus.flush_i)) begin
            if_rvalid      = 1'b1;
            bus.if_rdata_o = bus.mem_rdata_i;
          end
          drop_d  = 1'b0;
          state_d = StIdle;
        end else if (bus.flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    bus.if_rvalid_o = if_rvalid;
    bus.stall_o     = bus.ls_req_i | (state_q == StWaitLs) | (bus.if_req_i & ~if_rvalid);

    // Outputs are forced quiet while reset is held, including the combinational paths.
    if (!rst_n) begin
      bus.if_gnt_o    = 1'b0;
      bus.if_rvalid_o = 1'b0;
      bus.if_rdata_o  = '0;
      bus.ls_gnt_o    = 1'b0;
      bus.ls_rvalid_o = 1'b0;
      bus.ls_rdata_o  = '0;
      bus.mem_req_o   = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      bus.stall_o     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

`ifdef ARB_FAIRNESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model,
// plus a held-contention phase that counts who wins the grants.
module tb_mem_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic run_model = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the single outstanding transaction and who owns it.
  bit m_busy, m_ls, m_drop;
  int m_starve;
  bit n_busy, n_ls, n_drop;
  int n_starve;
  bit if_first, sel_ls, sel_if, idle, dropped;
  logic        e_req, e_we, e_ls_gnt, e_if_gnt, e_ls_rv, e_if_rv, e_stall;
  logic [31:0] e_addr, e_wdata, e_ls_rdata, e_if_rdata;

  initial begin
    m_busy = 0; m_ls = 0; m_drop = 0; m_starve = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_ls = 0; m_drop = 0; m_starve = 0;
      end
      if_first = 1'b0;
`ifdef ARB_FAIRNESS_EN
      if_first = bus.if_req_i && (m_starve >= int'(STARVE_LIMIT));
`endif
      sel_ls   = bus.ls_req_i && !if_first;
      sel_if   = bus.if_req_i && !sel_ls;
      idle     = !m_busy;
      e_req    = idle && (bus.ls_req_i || bus.if_req_i);
      e_addr   = !idle ? 32'h0 : sel_ls ? bus.ls_addr_i : sel_if ? bus.if_addr_i : 32'h0;
      e_we     = idle && sel_ls && bus.ls_we_i;
      e_wdata  = (idle && sel_ls) ? bus.ls_wdata_i : 32'h0;
      e_ls_gnt = idle && sel_ls && bus.mem_gnt_i;
      e_if_gnt = idle && sel_if && bus.mem_gnt_i;
      e_ls_rv  = m_busy && m_ls && bus.mem_rvalid_i;
      dropped  = m_drop || bus.flush_i;
      e_if_rv  = m_busy && !m_ls && bus.mem_rvalid_i && !dropped;
      e_ls_rdata = e_ls_rv ? bus.mem_rdata_i : 32'h0;
      e_if_rdata = e_if_rv ? bus.mem_rdata_i : 32'h0;
      e_stall  = bus.ls_req_i || (m_busy && m_ls) || (bus.if_req_i && !e_if_rv);

      n_busy = m_busy; n_ls = m_ls; n_drop = m_drop; n_starve = m_starve;
      if (e_ls_gnt) begin
        n_busy = 1; n_ls = 1;
        if (bus.if_req_i && m_starve < 7) n_starve = m_starve + 1;
      end else if (e_if_gnt) begin
        n_busy = 1; n_ls = 0; n_drop = bus.flush_i; n_starve = 0;
      end else if (m_busy && bus.mem_rvalid_i) begin
        n_busy = 0; n_drop = 0;
      end else if (m_busy && !m_ls && bus.flush_i) begin
        n_drop = 1;
      end

      if (!rst_n) begin
        e_req = 0; e_we = 0; e_ls_gnt = 0; e_if_gnt = 0; e_ls_rv = 0; e_if_rv = 0;
        e_stall = 0; e_addr = 0; e_wdata = 0; e_ls_rdata = 0; e_if_rdata = 0;
      end

      if (run_model) begin
        check_eq("mem_req", bus.mem_req_o, e_req);
        check_eq("mem_we", bus.mem_we_o, e_we);
        check_eq("mem_addr", bus.mem_addr_o, e_addr);
        check_eq("mem_wdata", bus.mem_wdata_o, e_wdata);
        check_eq("ls_gnt", bus.ls_gnt_o, e_ls_gnt);
        check_eq("if_gnt", bus.if_gnt_o, e_if_gnt);
        check_eq("ls_rvalid", bus.ls_rvalid_o, e_ls_rv);
        check_eq("ls_rdata", bus.ls_rdata_o, e_ls_rdata);
        check_eq("if_rvalid", bus.if_rvalid_o, e_if_rv);
        check_eq("if_rdata", bus.if_rdata_o, e_if_rdata);
        check_eq("stall", bus.stall_o, e_stall);
      end

      @(posedge clk);
      if (rst_n) begin
        m_busy = n_busy; m_ls = n_ls; m_drop = n_drop; m_starve = n_starve;
      end
    end
  end

  task automatic drive_idle_inputs();
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.ls_req_i = 0; bus.ls_we_i = 0;
    bus.ls_addr_i = 0; bus.ls_wdata_i = 0; bus.flush_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
  endtask

  int if_grants, ls_grants, exp_if_grants, exp_ls_grants;

  initial begin
    drive_idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      rst_n            = ($urandom_range(0, 149) != 0);
      bus.if_req_i     = ($urandom_range(0, 3) != 0);
      bus.if_addr_i    = $urandom;
      bus.ls_req_i     = ($urandom_range(0, 1) != 0);
      bus.ls_we_i      = ($urandom_range(0, 1) != 0);
      bus.ls_addr_i    = $urandom;
      bus.ls_wdata_i   = $urandom;
      bus.flush_i      = ($urandom_range(0, 5) == 0);
      bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid_i = ($urandom_range(0, 2) == 0);
      bus.mem_rdata_i  = $urandom;
    end

    // Held contention from a clean reset: every other cycle is a grant.
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive_idle_inputs();
    repeat (2) @(posedge clk);
    if_grants = 0;
    ls_grants = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      rst_n            = 1'b1;
      bus.if_req_i     = 1; bus.if_addr_i = 32'h10;
      bus.ls_req_i     = 1; bus.ls_we_i = 0; bus.ls_addr_i = 32'h100;
      bus.mem_gnt_i    = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h13;
      @(negedge clk);
      if (bus.if_gnt_o) if_grants++;
      if (bus.ls_gnt_o) ls_grants++;
    end
`ifdef ARB_FAIRNESS_EN
    exp_if_grants = 2;
    exp_ls_grants = 8;
`else
    exp_if_grants = 0;
    exp_ls_grants = 10;
`endif
    @(posedge clk);
    check_eq("fair_if_grants", if_grants, exp_if_grants);
    check_eq("fair_ls_grants", ls_grants, exp_ls_grants);

    #1 drive_idle_inputs();
    repeat (3) @(posedge clk);
    run_model = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
